reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 125 ++++++++++++
 tb/tb_reg_file_mp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register busy (scoreboard) bits, write-back
// bypass into the read ports, and issue/flush tracking of pending producers.
module reg_file_mp #(
    parameter int unsigned LEN      = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy_in,
    input  logic [NUM_RD*AW-1:0]     rd_idx,
    output logic [NUM_RD*LEN-1:0]    rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_idx,
    input  logic [LEN-1:0]           wr_data,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_idx,
    input  logic                     flush,
    output logic [AW:0]              busy_cnt,
    output logic [1:0]               rf_status
);

    localparam logic [1:0] ST_NOP      = 2'b00;
    localparam logic [1:0] ST_FINISHED = 2'b01;
    localparam logic [1:0] ST_CONFLICT = 2'b10;

    logic [LEN-1:0]          regs_q [NUM_REGS];
    logic [LEN-1:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     busy_q, busy_d;
    logic [NUM_RD*LEN-1:0]   rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]       rd_busy_q, rd_busy_d;
    logic [AW:0]             busy_cnt_q, busy_cnt_d;
    logic [1:0]              rf_status_q, rf_status_d;

    logic                    wr_ok;
    logic                    iss_ok;
    logic [AW-1:0]           ridx;

    // Next-state: storage, busy bits, captured read ports, count and status
    always_comb begin
        regs_d      = regs_q;
        busy_d      = busy_q;
        rd_data_d   = rd_data_q;
        rd_busy_d   = rd_busy_q;
        busy_cnt_d  = busy_cnt_q;
        rf_status_d = rf_status_q;
        ridx        = '0;
        wr_ok       = wr_en && (wr_idx != '0);
        iss_ok      = issue_en && (issue_idx != '0) && !flush;

        if (rdy_in) begin
            if (wr_ok) begin
                regs_d[wr_idx] = wr_data;
            end

            // Order matters: flush beats everything, a new issue beats a write-back
            if (flush) begin
                busy_d = '0;
            end else begin
                if (wr_ok) begin
                    busy_d[wr_idx] = 1'b0;
                end
                if (iss_ok) begin
                    busy_d[issue_idx] = 1'b1;
                end
            end
            busy_d[0] = 1'b0;

            for (int p = 0; p < int'(NUM_RD); p++) begin
                ridx = rd_idx[p*AW +: AW];
                if (ridx == '0) begin
                    rd_data_d[p*LEN +: LEN] = '0;
                end else if (wr_ok && (wr_idx == ridx)) begin
                    rd_data_d[p*LEN +: LEN] = wr_data;
                end else begin
                    rd_data_d[p*LEN +: LEN] = regs_q[ridx];
                end
                rd_busy_d[p] = busy_d[ridx];
            end

            busy_cnt_d = '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
            end

            if (iss_ok && busy_q[issue_idx] && !(wr_ok && (wr_idx == issue_idx))) begin
                rf_status_d = ST_CONFLICT;
            end else if (wr_ok) begin
                rf_status_d = ST_FINISHED;
            end else begin
                rf_status_d = ST_NOP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            busy_q      <= '0;
            rd_data_q   <= '0;
            rd_busy_q   <= '0;
            busy_cnt_q  <= '0;
            rf_status_q <= ST_NOP;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q      <= busy_d;
            rd_data_q   <= rd_data_d;
            rd_busy_q   <= rd_busy_d;
            busy_cnt_q  <= busy_cnt_d;
            rf_status_q <= rf_status_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_busy   = rd_busy_q;
    assign busy_cnt  = busy_cnt_q;
    assign rf_status = rf_status_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios with literal expectations plus a
// behavioural scoreboard model checked against the DUT on every cycle.
module tb_reg_file_mp;

    localparam int unsigned LEN = 32;
    localparam int unsigned NR  = 32;
    localparam int unsigned NP  = 2;
    localparam int unsigned AW  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy_in = 1'b1;
    logic [NP*AW-1:0]  rd_idx = '0;
    logic [NP*LEN-1:0] rd_data;
    logic [NP-1:0]     rd_busy;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_idx = '0;
    logic [LEN-1:0]    wr_data = '0;
    logic              issue_en = 1'b0;
    logic [AW-1:0]     issue_idx = '0;
    logic              flush = 1'b0;
    logic [AW:0]       busy_cnt;
    logic [1:0]        rf_status;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    reg_file_mp #(.LEN(LEN), .NUM_REGS(NR), .NUM_RD(NP)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .issue_en(issue_en), .issue_idx(issue_idx), .flush(flush),
        .busy_cnt(busy_cnt), .rf_status(rf_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural registers, pending-producer set, captured outputs
    logic [31:0] m_regs [NR];
    bit          m_busy [NR];
    logic [31:0] e_data [NP];
    bit          e_busy [NP];
    int          e_cnt;
    logic [1:0]  e_st;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NR); i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            for (int p = 0; p < int'(NP); p++) begin
                e_data[p] = '0;
                e_busy[p] = 1'b0;
            end
            e_cnt = 0;
            e_st  = 2'b00;
        end else if (rdy_in) begin
            int  r;
            bit  w_real;
            bit  i_real;
            w_real = wr_en && (wr_idx != 0);
            i_real = issue_en && (issue_idx != 0);
            for (int p = 0; p < int'(NP); p++) begin
                r = int'(rd_idx[p*AW +: AW]);
                if (r == 0) begin
                    e_data[p] = '0;
                    e_busy[p] = 1'b0;
                end else begin
                    e_data[p] = (w_real && int'(wr_idx) == r) ? wr_data : m_regs[r];
                    if (flush)                                e_busy[p] = 1'b0;
                    else if (i_real && int'(issue_idx) == r)  e_busy[p] = 1'b1;
                    else if (w_real && int'(wr_idx) == r)     e_busy[p] = 1'b0;
                    else                                      e_busy[p] = m_busy[r];
                end
            end
            if (i_real && !flush && m_busy[issue_idx] && !(w_real && wr_idx == issue_idx))
                e_st = 2'b10;
            else if (w_real)
                e_st = 2'b01;
            else
                e_st = 2'b00;
            if (w_real) m_regs[wr_idx] = wr_data;
            if (flush) begin
                for (int i = 0; i < int'(NR); i++) m_busy[i] = 1'b0;
            end else begin
                if (w_real) m_busy[wr_idx] = 1'b0;
                if (i_real) m_busy[issue_idx] = 1'b1;
            end
            e_cnt = 0;
            for (int i = 0; i < int'(NR); i++) e_cnt += int'(m_busy[i]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < int'(NP); p++) begin
                chk($sformatf("model rd_data[%0d]", p), rd_data[p*LEN +: LEN], e_data[p]);
                chk($sformatf("model rd_busy[%0d]", p), 32'(rd_busy[p]), 32'(e_busy[p]));
            end
            chk("model busy_cnt", 32'(busy_cnt), 32'(e_cnt));
            chk("model rf_status", 32'(rf_status), 32'(e_st));
        end
    end

    task automatic cyc(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ii, input logic fl,
                       input logic [4:0] r0, input logic [4:0] r1, input logic rdy);
        wr_en = we; wr_idx = wi; wr_data = wd;
        issue_en = ie; issue_idx = ii; flush = fl;
        rd_idx = {r1, r0}; rdy_in = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                           input logic b0, input logic b1, input int cnt, input logic [1:0] st);
        chk({nm, " data0"}, rd_data[31:0], d0);
        chk({nm, " data1"}, rd_data[63:32], d1);
        chk({nm, " busy0"}, 32'(rd_busy[0]), 32'(b0));
        chk({nm, " busy1"}, 32'(rd_busy[1]), 32'(b1));
        chk({nm, " cnt"}, 32'(busy_cnt), 32'(cnt));
        chk({nm, " status"}, 32'(rf_status), 32'(st));
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk_out("reset", 0, 0, 0, 0, 0, 2'b00);

        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1);
        chk_out("wr x5", 0, 0, 0, 0, 0, 2'b01);
        cyc(0, 0, 0, 0, 0, 0, 5, 0, 1);
        chk_out("rd x5", 32'hDEADBEEF, 0, 0, 0, 0, 2'b00);

        cyc(1, 0, 32'h1234, 1, 0, 0, 0, 0, 1);
        chk_out("x0 wr+issue", 0, 0, 0, 0, 0, 2'b00);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_out("x0 reread", 0, 0, 0, 0, 0, 2'b00);

        cyc(1, 7, 32'hA5A5A5A5, 0, 0, 0, 7, 7, 1);
        chk_out("bypass x7", 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 2'b01);

        cyc(0, 0, 0, 1, 3, 0, 3, 0, 1);
        chk_out("issue x3", 0, 0, 1, 0, 1, 2'b00);
        cyc(0, 0, 0, 1, 3, 0, 3, 0, 1);
        chk_out("reissue x3", 0, 0, 1, 0, 1, 2'b10);
        cyc(1, 3, 32'h11, 1, 3, 0, 3, 3, 1);
        chk_out("wr+issue x3", 32'h11, 32'h11, 1, 1, 1, 2'b01);
        cyc(0, 0, 0, 0, 0, 0, 3, 0, 1);
        chk_out("rd x3", 32'h11, 0, 1, 0, 1, 2'b00);

        cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
        chk_out("flush pre", 0, 0, 0, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 2, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 4, 0, 2, 4, 1);
        chk_out("issue 1,2,4", 0, 0, 1, 1, 3, 2'b00);
        cyc(1, 2, 32'h55, 1, 9, 1, 2, 9, 1);
        chk_out("flush+issue+wr", 32'h55, 0, 0, 0, 0, 2'b01);
        cyc(0, 0, 0, 0, 0, 0, 2, 9, 1);
        chk_out("after flush", 32'h55, 0, 0, 0, 0, 2'b00);

        cyc(0, 0, 0, 0, 0, 0, 5, 7, 1);
        chk_out("pre hold", 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 0, 2'b00);
        cyc(1, 6, 32'h77, 1, 6, 0, 6, 6, 0);
        chk_out("hold", 32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 0, 2'b00);
        cyc(0, 0, 0, 0, 0, 0, 6, 6, 1);
        chk_out("x6 unchanged", 0, 0, 0, 0, 0, 2'b00);
        cyc(0, 0, 0, 1, 8, 0, 7, 8, 1);
        chk_out("pre async", 32'hA5A5A5A5, 0, 0, 1, 1, 2'b00);
        rdy_in = 1'b0;
        #2 rst = 1'b1;
        #1 chk_out("async rst", 0, 0, 0, 0, 0, 2'b00);
        #1 rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 7, 5, 1);
        chk_out("post rst", 0, 0, 0, 0, 0, 2'b00);

        for (int k = 0; k < 300; k++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 15) == 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 7) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
